// File: rtl/mult16_pp_seq_pkg.sv
// Shared constants for the sequential partial-product generator:
// FSM state encoding, partial-product select codes and default operand width.
package mult16_pp_seq_pkg;

   localparam int N_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] PP_LL = 2'd0;
   localparam logic [1:0] PP_HL = 2'd1;
   localparam logic [1:0] PP_LH = 2'd2;
   localparam logic [1:0] PP_HH = 2'd3;

endpackage

// File: rtl/mult16_pp_seq_mult_half.sv
// Combinational unsigned H x H -> 2H multiplier, kept separate so it can be
// retargeted to a DSP slice or LUT fabric without touching the control logic.
module mult_half #(
   parameter int H = 8
) (
   input  logic [H-1:0]   x,
   input  logic [H-1:0]   y,
   output logic [2*H-1:0] p
);

   assign p = x * y;

endmodule

// File: rtl/mult16_pp_seq.sv
// Sequential partial-product generator: one accepted operand pair yields four
// half-width products over four cycles through a single shared multiplier.
module mult16_pp_seq
   import mult16_pp_seq_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] prod1,
   output logic [N-1:0] prod2,
   output logic [N-1:0] prod3,
   output logic [N-1:0] prod4
);

   localparam int H = N / 2;

   state_e       state_q, state_d;
   logic [1:0]   k_q, k_d;
   logic [N-1:0] a_q, a_d, b_q, b_d;
   logic [N-1:0] prod1_q, prod1_d, prod2_q, prod2_d;
   logic [N-1:0] prod3_q, prod3_d, prod4_q, prod4_d;
   logic         out_valid_q, out_valid_d;

   logic         accept;
   logic [H-1:0] mul_x, mul_y;
   logic [N-1:0] mul_p;

   assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   // k[0] picks the high half of a, k[1] the high half of b
   assign mul_x = k_q[0] ? a_q[N-1:H] : a_q[H-1:0];
   assign mul_y = k_q[1] ? b_q[N-1:H] : b_q[H-1:0];

   mult_half #(.H(H)) u_mult_half (
      .x (mul_x),
      .y (mul_y),
      .p (mul_p)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      prod1_d = prod1_q;
      prod2_d = prod2_q;
      prod3_d = prod3_q;
      prod4_d = prod4_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = a;
               b_d     = b;
               k_d     = 2'd0;
               state_d = MUL;
            end
         end
         MUL: begin
            case (k_q)
               PP_LL:   prod1_d = mul_p;
               PP_HL:   prod2_d = mul_p;
               PP_LH:   prod3_d = mul_p;
               default: prod4_d = mul_p;
            endcase
            k_d = k_q + 2'd1;
            if (k_q == PP_HH) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  a_d     = a;
                  b_d     = b;
                  k_d     = 2'd0;
                  state_d = MUL;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= 2'd0;
         a_q         <= '0;
         b_q         <= '0;
         prod1_q     <= '0;
         prod2_q     <= '0;
         prod3_q     <= '0;
         prod4_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         a_q         <= a_d;
         b_q         <= b_d;
         prod1_q     <= prod1_d;
         prod2_q     <= prod2_d;
         prod3_q     <= prod3_d;
         prod4_q     <= prod4_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign prod1     = prod1_q;
   assign prod2     = prod2_q;
   assign prod3     = prod3_q;
   assign prod4     = prod4_q;

endmodule
